spike_rate_decoder: RTL and testbench

SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

---
 rtl/spike_rate_decoder.sv | 133 +++++++++++++
 tb/tb_spike_rate_decoder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/spike_rate_decoder.sv
// Counts spikes per win_len-cycle window; rate_valid rises the cycle after closure, held until rate_ready; late result overwrites and sets overrun.
// Optional ISI measurement (isi/isi_valid, one-cycle latency) is built only with SPIKE_RATE_DECODER_ISI_EN defined.
module spike_rate_decoder #(
    parameter int RATE_W = 8,
    parameter int ISI_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              spike,
    input  logic [7:0]        win_len,
    input  logic              rate_ready,
    output logic [RATE_W-1:0] rate,
    output logic              rate_valid,
    output logic              overrun,
    output logic [ISI_W-1:0]  isi,
    output logic              isi_valid
);

    typedef enum logic {IDLE, COUNT} state_t;

    localparam logic [RATE_W-1:0] RATE_ONE = 1;
    localparam logic [RATE_W-1:0] RATE_MAX = '1;

    state_t            state;
    state_t            state_next;
    logic [RATE_W-1:0] cnt;
    logic [RATE_W-1:0] cnt_inc;
    logic [8:0]        cyc;
    logic [8:0]        win_q;
    logic              running;
    logic              win_close;
    logic              accept;

    // A window length of 0 encodes 256 cycles.
    function automatic logic [8:0] win_cycles(input logic [7:0] w);
        return (w == 8'd0) ? 9'd256 : {1'b0, w};
    endfunction

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable)  state_next = COUNT;
            COUNT:   if (!enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        running   = (state == COUNT) && enable;
        win_close = running && (cyc == win_q - 9'd1);
        accept    = rate_valid && rate_ready;
        cnt_inc   = cnt;
        if (running && spike && (cnt != RATE_MAX))
            cnt_inc = cnt + RATE_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            cyc        <= '0;
            win_q      <= '0;
            rate       <= '0;
            rate_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state <= state_next;
            if (accept)
                rate_valid <= 1'b0;
            if (state == IDLE) begin
                overrun <= 1'b0;
                cnt     <= '0;
                cyc     <= '0;
                win_q   <= win_cycles(win_len);
            end else if (!enable) begin
                cnt <= '0;
                cyc <= '0;
            end else if (win_close) begin
                // Closure wins over a same-edge acceptance; only an unaccepted result counts as overrun.
                rate       <= cnt_inc;
                rate_valid <= 1'b1;
                if (rate_valid && !rate_ready)
                    overrun <= 1'b1;
                cnt   <= '0;
                cyc   <= '0;
                win_q <= win_cycles(win_len);
            end else begin
                cnt <= cnt_inc;
                cyc <= cyc + 9'd1;
            end
        end
    end

`ifdef SPIKE_RATE_DECODER_ISI_EN
    localparam logic [ISI_W-1:0] ISI_ONE = 1;
    localparam logic [ISI_W-1:0] ISI_MAX = '1;

    logic [ISI_W-1:0] isi_cnt;
    logic             armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            isi_cnt   <= '0;
            armed     <= 1'b0;
            isi       <= '0;
            isi_valid <= 1'b0;
        end else begin
            isi_valid <= 1'b0;
            if (running) begin
                // isi_cnt holds cycles elapsed since the last spike.
                if (spike) begin
                    if (armed) begin
                        isi       <= isi_cnt;
                        isi_valid <= 1'b1;
                    end
                    armed   <= 1'b1;
                    isi_cnt <= ISI_ONE;
                end else if (isi_cnt != ISI_MAX) begin
                    isi_cnt <= isi_cnt + ISI_ONE;
                end
            end else begin
                armed   <= 1'b0;
                isi_cnt <= '0;
            end
        end
    end
`else
    assign isi       = '0;
    assign isi_valid = 1'b0;
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Randomized + directed bench: queue-based window model pushes per-cycle expectations, monitor pops and compares.
module tb_spike_rate_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       spike = 1'b0;
    logic       rate_ready = 1'b0;
    logic [7:0] win_len = 8'd0;

    logic [7:0] rate;
    logic       rate_valid;
    logic       overrun;
    logic [7:0] isi;
    logic       isi_valid;
    logic [1:0] rate2;
    logic       rate_valid2;
    logic       overrun2;
    logic [7:0] isi2;
    logic       isi_valid2;

    spike_rate_decoder #(.RATE_W(8), .ISI_W(8)) dut (
        .clk(clk), .rst(rst), .enable(enable), .spike(spike), .win_len(win_len),
        .rate_ready(rate_ready), .rate(rate), .rate_valid(rate_valid),
        .overrun(overrun), .isi(isi), .isi_valid(isi_valid)
    );

    spike_rate_decoder #(.RATE_W(2), .ISI_W(8)) dut_narrow (
        .clk(clk), .rst(rst), .enable(enable), .spike(spike), .win_len(win_len),
        .rate_ready(rate_ready), .rate(rate2), .rate_valid(rate_valid2),
        .overrun(overrun2), .isi(isi2), .isi_valid(isi_valid2)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string name, input int got, input int exp);
        compared++;
        if (got != exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    typedef struct {
        bit rv;
        int n;
        bit ov;
        int isi;
        bit isiv;
    } snap_t;

    snap_t exp_q[$];

    // Reference model: a window is a list of spike bits; results are a pending list.
    bit    m_run;
    bit    win_bits[$];
    int    win_target;
    int    rq[$];
    int    m_last_n;
    bit    m_ov;
    int    m_isi;
    bit    m_isiv;
    int    cidx;
    int    last_sp;
    bit    armed;
    bit    acc;
    int    n;
    snap_t s;

    function automatic int winlen(input logic [7:0] w);
        return (w == 8'd0) ? 256 : int'(w);
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_run = 0; win_bits.delete(); rq.delete(); m_last_n = 0; m_ov = 0;
            m_isi = 0; m_isiv = 0; cidx = 0; last_sp = 0; armed = 0; win_target = 0;
            exp_q.delete();
        end else begin
            acc    = (rq.size() > 0) && rate_ready;
            m_isiv = 0;
            if (!m_run) begin
                m_ov = 0;
                if (acc) void'(rq.pop_front());
                if (enable) begin
                    m_run = 1; win_target = winlen(win_len); win_bits.delete();
                    armed = 0; cidx = 0;
                end
            end else if (!enable) begin
                m_run = 0; win_bits.delete();
                if (acc) void'(rq.pop_front());
            end else begin
                cidx++;
                if (spike) begin
                    if (armed) begin
                        m_isi = sat(cidx - last_sp, 255); m_isiv = 1;
                    end
                    armed = 1; last_sp = cidx;
                end
                win_bits.push_back(spike);
                if (win_bits.size() == win_target) begin
                    n = 0;
                    foreach (win_bits[i]) n += int'(win_bits[i]);
                    if (rq.size() > 0 && !rate_ready) m_ov = 1;
                    rq.delete(); rq.push_back(n); m_last_n = n;
                    win_bits.delete(); win_target = winlen(win_len);
                end else if (acc) begin
                    void'(rq.pop_front());
                end
            end
            s.rv = rq.size() > 0; s.n = m_last_n; s.ov = m_ov; s.isi = m_isi; s.isiv = m_isiv;
            exp_q.push_back(s);
        end
    end

    snap_t e;
    initial forever begin
        @(posedge clk);
        #1;
        if (rst) begin
            chk("rst_rate", rate, 0);           chk("rst_rate_valid", rate_valid, 0);
            chk("rst_overrun", overrun, 0);     chk("rst_isi", isi, 0);
            chk("rst_isi_valid", isi_valid, 0); chk("rst_rate2", rate2, 0);
        end else if (exp_q.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL scoreboard at %0t: got no expectation, required one per cycle", $time);
        end else begin
            e = exp_q.pop_front();
            chk("rate_valid", rate_valid, e.rv);
            chk("rate", rate, sat(e.n, 255));
            chk("overrun", overrun, e.ov);
            chk("rate_valid2", rate_valid2, e.rv);
            chk("rate2", rate2, sat(e.n, 3));
            chk("overrun2", overrun2, e.ov);
`ifdef SPIKE_RATE_DECODER_ISI_EN
            chk("isi", isi, e.isi);
            chk("isi_valid", isi_valid, e.isiv);
            chk("isi2", isi2, e.isi);
            chk("isi_valid2", isi_valid2, e.isiv);
`else
            chk("isi", isi, 0);
            chk("isi_valid", isi_valid, 0);
            chk("isi2", isi2, 0);
            chk("isi_valid2", isi_valid2, 0);
`endif
        end
    end

    task automatic cyc(input logic en, input logic sp, input logic rdy, input logic [7:0] wl);
        enable = en; spike = sp; rate_ready = rdy; win_len = wl;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog at %0t: got no end of stimulus, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    bit seen;
    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) cyc(0, 0, 1, 8'd10);

        // Window of 10 with three spikes, consumer always ready.
        cyc(1, 0, 1, 8'd10);
        for (int i = 1; i <= 14; i++) cyc(1, (i == 2 || i == 5 || i == 7), 1, 8'd10);
        repeat (2) cyc(0, 0, 1, 8'd4);

        // Stalled consumer across three short windows.
        cyc(1, 1, 0, 8'd4);
        for (int i = 1; i <= 13; i++) cyc(1, 1, 0, 8'd4);
        repeat (2) cyc(1, 1, 1, 8'd4);
        repeat (2) cyc(0, 0, 1, 8'd8);

        // Saturation of the narrow instance.
        cyc(1, 1, 1, 8'd8);
        for (int i = 1; i <= 10; i++) cyc(1, 1, 1, 8'd8);
        repeat (2) cyc(0, 0, 1, 8'd10);

        // Partial window discarded on enable drop.
        cyc(1, 0, 1, 8'd10);
        for (int i = 1; i <= 5; i++) cyc(1, (i == 2 || i == 4), 1, 8'd10);
        repeat (3) cyc(0, 1, 1, 8'd10);
        cyc(1, 0, 1, 8'd10);
        for (int i = 1; i <= 12; i++) cyc(1, (i % 3 == 0), 1, 8'd10);
        repeat (2) cyc(0, 0, 1, 8'd0);

        // Inter-spike intervals at COUNT cycles 2, 7, 300.
        cyc(1, 0, 1, 8'd0);
        for (int i = 1; i <= 305; i++) cyc(1, (i == 2 || i == 7 || i == 300), 1, 8'd0);
        repeat (2) cyc(0, 0, 1, 8'd5);

        // Random traffic, occasionally long windows and dense bursts.
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] wl;
            wl = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(1, 6));
            cyc($urandom_range(0, 24) != 0,
                (i % 700 < 300) ? ($urandom_range(0, 7) != 0) : 1'($urandom),
                $urandom_range(0, 2) != 0, wl);
        end
        repeat (2) cyc(0, 0, 1, 8'd3);

        // Asynchronous reset mid-window with a result pending.
        cyc(1, 0, 0, 8'd3);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cyc(1, 1, 0, 8'd3);
            seen = rate_valid;
        end
        chk("pending_before_rst", rate_valid, 1);
        cyc(1, 1, 0, 8'd3);
        rst = 1'b1;
        #1;
        chk("async_rate", rate, 0);           chk("async_rate_valid", rate_valid, 0);
        chk("async_overrun", overrun, 0);     chk("async_isi", isi, 0);
        chk("async_isi_valid", isi_valid, 0); chk("async_rate2", rate2, 0);
        chk("async_rate_valid2", rate_valid2, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) cyc(1, 1'($urandom), 1, 8'd3);
        repeat (3) cyc(0, 0, 1, 8'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
